epb_sync_bridge: RTL



---
 rtl/epb_sync_bridge_pkg.sv | 24 ++
 rtl/epb_sync_bridge_if.sv | 55 +++++
 rtl/epb_timeout_ctr.sv | 48 ++++
 rtl/epb_sync_bridge.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/epb_sync_bridge_pkg.sv
// Shared definitions for the EPB synchronous bridge.
// Contents: FSM state encoding, read fill bit (all-ones on timeout),
// timeout event counter width and a saturating increment helper.
package epb_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStrobe = 3'd1,
        StWait   = 3'd2,
        StReady  = 3'd3,
        StHold   = 3'd4
    } epb_state_e;

    // Width of the saturating timed-out-cycle counter.
    localparam int unsigned TO_CNT_W = 16;

    // Read data returned on a timed-out read is this bit replicated.
    localparam logic RD_FILL_BIT = 1'b1;

    function automatic logic [TO_CNT_W-1:0] sat_inc(input logic [TO_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/epb_sync_bridge_if.sv
// Bundle of EPB pad-side and internal register-bus signals for the bridge.
// Modports:
//   slave  - the bridge view (EPB slave, register-bus initiator)
//   master - the processor/decoder view (drives EPB, answers the register bus)
interface epb_sync_bridge_if
    import epb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 23,
    parameter int unsigned GP_WIDTH   = 6
);
    localparam int unsigned BE_W = DATA_WIDTH / 8;
    localparam int unsigned BA_W = GP_WIDTH + ADDR_WIDTH;

    // EPB side
    logic                  epb_cs_n;
    logic                  epb_oe_n;
    logic                  epb_r_w_n;
    logic [BE_W-1:0]       epb_be_n;
    logic [ADDR_WIDTH-1:0] epb_addr;
    logic [GP_WIDTH-1:0]   epb_addr_gp;
    logic [DATA_WIDTH-1:0] epb_data_in;
    logic [DATA_WIDTH-1:0] epb_data_out;
    logic                  epb_data_oe_n;
    logic                  epb_rdy;
    logic                  epb_rdy_oe;

    // Internal register bus
    logic [BA_W-1:0]       bus_addr;
    logic [BE_W-1:0]       bus_be;
    logic [DATA_WIDTH-1:0] bus_wr_data;
    logic                  bus_wr_en;
    logic                  bus_rd_en;
    logic [DATA_WIDTH-1:0] bus_rd_data;
    logic                  bus_ack;

    logic [TO_CNT_W-1:0]   timeout_count;

    modport slave (
        input  epb_cs_n, epb_oe_n, epb_r_w_n, epb_be_n, epb_addr, epb_addr_gp, epb_data_in,
        output epb_data_out, epb_data_oe_n, epb_rdy, epb_rdy_oe,
        output bus_addr, bus_be, bus_wr_data, bus_wr_en, bus_rd_en,
        input  bus_rd_data, bus_ack,
        output timeout_count
    );

    modport master (
        output epb_cs_n, epb_oe_n, epb_r_w_n, epb_be_n, epb_addr, epb_addr_gp, epb_data_in,
        input  epb_data_out, epb_data_oe_n, epb_rdy, epb_rdy_oe,
        input  bus_addr, bus_be, bus_wr_data, bus_wr_en, bus_rd_en,
        output bus_rd_data, bus_ack,
        input  timeout_count
    );

endinterface

// File: rtl/epb_timeout_ctr.sv
// Per-transaction wait counter plus saturating count of timed-out cycles.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   i_clear         - load the wait counter with zero
//   i_en            - advance the wait counter (holds at terminal)
//   o_terminal      - wait counter equals TIMEOUT-1
//   i_event         - a cycle timed out; bump the event counter
//   o_event_count   - saturating timed-out-cycle count
module epb_timeout_ctr
    import epb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,
    input  logic                i_en,
    output logic                o_terminal,
    input  logic                i_event,
    output logic [TO_CNT_W-1:0] o_event_count
);
    localparam logic [15:0] TERM = 16'(TIMEOUT - 1);

    logic [15:0]         r_count;
    logic [TO_CNT_W-1:0] r_events;

    assign o_terminal    = (r_count == TERM);
    assign o_event_count = r_events;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && !o_terminal) begin
            r_count <= r_count + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_events <= '0;
        end else if (i_event) begin
            r_events <= sat_inc(r_events);
        end
    end

endmodule

// File: rtl/epb_sync_bridge.sv
// EPB slave bridge: registers the EPB inputs once, turns each EPB cycle into a
// single-cycle read/write strobe on the internal register bus, waits for
// bus_ack (bounded by TIMEOUT) and returns the EPB ready pulse.
// Ports:
//   epb_clk, epb_rst - clock, asynchronous active-high reset
//   epb              - slave modport carrying EPB pad signals, register bus
//                      signals and the timed-out-cycle count
module epb_sync_bridge
    import epb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 23,
    parameter int unsigned GP_WIDTH   = 6,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic               epb_clk,
    input logic               epb_rst,
    epb_sync_bridge_if.slave  epb
);
    localparam int unsigned BE_W = DATA_WIDTH / 8;
    localparam int unsigned BA_W = GP_WIDTH + ADDR_WIDTH;

    // Input stage S1
    logic                  r_s1_cs_n;
    logic                  r_s1_oe_n;
    logic                  r_s1_r_w_n;
    logic [BE_W-1:0]       r_s1_be_n;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic [GP_WIDTH-1:0]   r_s1_gp;
    logic [DATA_WIDTH-1:0] r_s1_data;

    // Transaction state
    epb_state_e            r_state, w_state_d;
    logic [BA_W-1:0]       r_bus_addr;
    logic [BE_W-1:0]       r_bus_be;
    logic [DATA_WIDTH-1:0] r_bus_wr_data;
    logic                  r_rnw;
    logic                  r_ack;
    logic                  w_ack_d;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0] r_data_out, w_data_out_d;

    logic w_latch;
    logic w_ctr_clear;
    logic w_ctr_en;
    logic w_ctr_term;
    logic w_to_event;
    logic w_drive_phase;

    always_ff @(posedge epb_clk or posedge epb_rst) begin
        if (epb_rst) begin
            r_s1_cs_n  <= 1'b1;
            r_s1_oe_n  <= 1'b1;
            r_s1_r_w_n <= 1'b1;
            r_s1_be_n  <= '1;
            r_s1_addr  <= '0;
            r_s1_gp    <= '0;
            r_s1_data  <= '0;
        end else begin
            r_s1_cs_n  <= epb.epb_cs_n;
            r_s1_oe_n  <= epb.epb_oe_n;
            r_s1_r_w_n <= epb.epb_r_w_n;
            r_s1_be_n  <= epb.epb_be_n;
            r_s1_addr  <= epb.epb_addr;
            r_s1_gp    <= epb.epb_addr_gp;
            r_s1_data  <= epb.epb_data_in;
        end
    end

    epb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk           (epb_clk),
        .rst           (epb_rst),
        .i_clear       (w_ctr_clear),
        .i_en          (w_ctr_en),
        .o_terminal    (w_ctr_term),
        .i_event       (w_to_event),
        .o_event_count (epb.timeout_count)
    );

    always_comb begin
        w_state_d    = r_state;
        w_ack_d      = 1'b0;
        w_data_out_d = r_data_out;
        w_latch      = 1'b0;
        w_ctr_clear  = 1'b0;
        w_ctr_en     = 1'b0;
        w_to_event   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!r_s1_cs_n) begin
                    w_latch   = 1'b1;
                    w_state_d = StStrobe;
                end
            end
            StStrobe: begin
                w_ctr_clear = 1'b1;
                if (r_s1_cs_n) begin
                    w_state_d = StIdle;
                end else begin
                    // An ack alongside the strobe is held for WAIT's first cycle.
                    w_ack_d   = epb.bus_ack;
                    w_state_d = StWait;
                end
            end
            StWait: begin
                w_ctr_en = 1'b1;
                if (r_s1_cs_n) begin
                    w_state_d = StIdle;
                end else if (r_ack) begin
                    // Ack beats a simultaneous timeout.
                    if (r_rnw) w_data_out_d = r_rd_data;
                    w_state_d = StReady;
                end else if (w_ctr_term) begin
                    if (r_rnw) w_data_out_d = {DATA_WIDTH{RD_FILL_BIT}};
                    w_to_event = 1'b1;
                    w_state_d  = StReady;
                end else begin
                    w_ack_d = epb.bus_ack;
                end
            end
            StReady: w_state_d = StHold;
            StHold: begin
                if (r_s1_cs_n) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge epb_clk or posedge epb_rst) begin
        if (epb_rst) begin
            r_state       <= StIdle;
            r_ack         <= 1'b0;
            r_rd_data     <= '0;
            r_data_out    <= '0;
            r_bus_addr    <= '0;
            r_bus_be      <= '0;
            r_bus_wr_data <= '0;
            r_rnw         <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_ack      <= w_ack_d;
            r_data_out <= w_data_out_d;
            if (w_ack_d) r_rd_data <= epb.bus_rd_data;
            if (w_latch) begin
                r_bus_addr    <= {r_s1_gp, r_s1_addr};
                r_bus_be      <= ~r_s1_be_n;
                r_bus_wr_data <= r_s1_data;
                r_rnw         <= r_s1_r_w_n;
            end
        end
    end

    assign w_drive_phase = (r_state == StReady) || (r_state == StHold);

    assign epb.bus_addr      = r_bus_addr;
    assign epb.bus_be        = r_bus_be;
    assign epb.bus_wr_data   = r_bus_wr_data;
    assign epb.bus_wr_en     = (r_state == StStrobe) && !r_rnw;
    assign epb.bus_rd_en     = (r_state == StStrobe) && r_rnw;
    assign epb.epb_data_out  = r_data_out;
    assign epb.epb_rdy       = (r_state == StReady);
    assign epb.epb_rdy_oe    = w_drive_phase;
    assign epb.epb_data_oe_n = !(w_drive_phase && r_rnw && !r_s1_oe_n);

endmodule
